// File: rtl/cpu_defs.sv
// Shared definitions for the SIMPLE RISC control stage.
// Contents: FSM state encoding, memory command codes, opcode/op field
// values, ALU operation codes and writeback-source (vsel) codes.
package cpu_defs;

    typedef enum logic [4:0] {
        S_RST      = 5'd0,
        S_IF1      = 5'd1,
        S_IF2      = 5'd2,
        S_UPD_PC   = 5'd3,
        S_DECODE   = 5'd4,
        S_MOV_IMM  = 5'd5,
        S_GET_A    = 5'd6,
        S_GET_B    = 5'd7,
        S_ALU      = 5'd8,
        S_WR_REG   = 5'd9,
        S_ADDR     = 5'd10,
        S_LD_ADDR  = 5'd11,
        S_LDR_RD1  = 5'd12,
        S_LDR_RD2  = 5'd13,
        S_STR_GETB = 5'd14,
        S_STR_C    = 5'd15,
        S_STR_WR   = 5'd16,
        S_HALT     = 5'd17
    } state_t;

    // Memory command
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // Opcode field IR[15:13]
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Op field IR[12:11]
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MEM     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALU operation
    localparam logic [1:0] ALU_ADD = 2'b00;

    // Register-file writeback source
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Shifter control for the address and store paths
    localparam logic [1:0] SHIFT_NONE = 2'b00;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction field decoder.
// Ports:
//   ir      in  16  instruction register contents
//   opcode  out 3   IR[15:13]
//   op      out 2   IR[12:11]
//   rn      out 3   IR[10:8]
//   rd      out 3   IR[7:5]
//   sh      out 2   IR[4:3]
//   rm      out 3   IR[2:0]
//   sximm5  out 16  IR[4:0] sign-extended
//   sximm8  out 16  IR[7:0] sign-extended
module instr_decoder (
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/cpu_controller.sv
// Control stage for the 16-bit SIMPLE RISC datapath: holds the instruction
// register and runs a Moore FSM that sequences fetch, PC update, decode and
// execute. All control outputs are combinational from state and IR.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mdata                      memory read data, captured into IR in IF2
//   mem_cmd, addr_sel          memory command and address source
//   load_pc, reset_pc          PC register control
//   load_addr                  data address register enable
//   readnum, writenum, write   register file control
//   loada..loads, asel, bsel   datapath register enables and operand selects
//   vsel, shift, ALUop         writeback source, shifter and ALU control
//   sximm5, sximm8             sign-extended immediates from IR
//   halted                     high while in HALT
//   fsm_state                  current FSM state (observability)
module cpu_controller
    import cpu_defs::*;
#(
    parameter int DATA_W       = 16,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mdata,
    output logic [1:0]        mem_cmd,
    output logic              addr_sel,
    output logic              load_pc,
    output logic              reset_pc,
    output logic              load_addr,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic              halted,
    output state_t            fsm_state
);

    state_t            state, state_next;
    logic [DATA_W-1:0] ir;
    logic              ir_load;
    logic [2:0]        opcode, rn, rd, rm;
    logic [1:0]        op, sh;
    state_t            decode_target;
    state_t            illegal_target;

    instr_decoder u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm5 (sximm5),
        .sximm8 (sximm8)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RST;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (ir_load) ir <= mdata;
        end
    end

    assign fsm_state      = state;
    assign illegal_target = ILLEGAL_TRAP ? S_HALT : S_IF1;

    // Dispatch from DECODE. MOV reg and MVN skip GET_A because they only
    // need the B operand (A is forced to 0 or ignored by NOT B).
    always_comb begin
        decode_target = illegal_target;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)      decode_target = S_MOV_IMM;
                else if (op == OP_MOV_REG) decode_target = S_GET_B;
            end
            OPC_ALU:  decode_target = (op == OP_MVN) ? S_GET_B : S_GET_A;
            OPC_LDR,
            OPC_STR:  if (op == OP_MEM) decode_target = S_GET_A;
            OPC_HALT: decode_target = S_HALT;
            default:  decode_target = illegal_target;
        endcase
    end

    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        mem_cmd    = MNONE;
        addr_sel   = 1'b0;
        load_pc    = 1'b0;
        reset_pc   = 1'b0;
        load_addr  = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = VSEL_C;
        shift      = SHIFT_NONE;
        ALUop      = ALU_ADD;
        halted     = 1'b0;
        case (state)
            S_RST: begin
                reset_pc   = 1'b1;
                load_pc    = 1'b1;
                state_next = S_IF1;
            end
            S_IF1: begin
                addr_sel   = 1'b1;
                mem_cmd    = MREAD;
                state_next = S_IF2;
            end
            S_IF2: begin
                addr_sel   = 1'b1;
                mem_cmd    = MREAD;
                ir_load    = 1'b1;
                state_next = S_UPD_PC;
            end
            S_UPD_PC: begin
                load_pc    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: state_next = decode_target;
            S_MOV_IMM: begin
                writenum   = rn;
                vsel       = VSEL_IMM8;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = (opcode == OPC_ALU) ? S_GET_B : S_ADDR;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = S_ALU;
            end
            S_ALU: begin
                shift = sh;
                ALUop = op;
                // MOV reg computes 0 + shifted Rm, so A is forced to zero.
                asel  = (opcode == OPC_MOV);
                if (opcode == OPC_ALU && op == OP_CMP) begin
                    loads      = 1'b1;
                    state_next = S_IF1;
                end else begin
                    loadc      = 1'b1;
                    state_next = S_WR_REG;
                end
            end
            S_WR_REG: begin
                writenum   = rd;
                vsel       = VSEL_C;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_ADDR: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_LD_ADDR;
            end
            S_LD_ADDR: begin
                load_addr  = 1'b1;
                state_next = (opcode == OPC_LDR) ? S_LDR_RD1 : S_STR_GETB;
            end
            S_LDR_RD1: begin
                mem_cmd    = MREAD;
                state_next = S_LDR_RD2;
            end
            S_LDR_RD2: begin
                mem_cmd    = MREAD;
                writenum   = rd;
                vsel       = VSEL_MDATA;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_STR_GETB: begin
                readnum    = rd;
                loadb      = 1'b1;
                state_next = S_STR_C;
            end
            S_STR_C: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_STR_WR;
            end
            S_STR_WR: begin
                mem_cmd    = MWRITE;
                state_next = S_IF1;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
            default: state_next = S_RST;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: each instruction's expected per-cycle
// control vectors are queued when mdata is driven, then popped and compared
// one per clock.
module tb_cpu_controller;
    import cpu_defs::*;

    typedef struct packed {
        state_t     st;
        logic [1:0] mem_cmd;
        logic       addr_sel;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       halted;
    } ctl_t;

    localparam int CW = $bits(ctl_t);

    logic        clk;
    logic        reset;
    logic [15:0] mdata;
    logic [1:0]  mem_cmd;
    logic        addr_sel, load_pc, reset_pc, load_addr;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift, alu_op;
    logic [15:0] sximm5, sximm8;
    logic        halted;
    state_t      fsm_state;

    logic [CW-1:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;

    ctl_t obs;
    assign obs = {fsm_state, mem_cmd, addr_sel, load_pc, reset_pc, load_addr,
                  readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, vsel, shift, alu_op, halted};

    cpu_controller #(.DATA_W(16), .ILLEGAL_TRAP(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .mdata     (mdata),
        .mem_cmd   (mem_cmd),
        .addr_sel  (addr_sel),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .load_addr (load_addr),
        .readnum   (readnum),
        .writenum  (writenum),
        .write     (write),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .vsel      (vsel),
        .shift     (shift),
        .ALUop     (alu_op),
        .sximm5    (sximm5),
        .sximm8    (sximm8),
        .halted    (halted),
        .fsm_state (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Helpers building expected vectors
    function automatic ctl_t st_only(input state_t s);
        ctl_t c;
        c    = '0;
        c.st = s;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_rst();
        ctl_t c;
        c = st_only(S_RST); c.reset_pc = 1'b1; c.load_pc = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_if1();
        ctl_t c;
        c = st_only(S_IF1); c.addr_sel = 1'b1; c.mem_cmd = 2'b01;
        exp_q.push_back(c);
    endtask

    task automatic push_fetch();
        ctl_t c;
        push_if1();
        c = st_only(S_IF2); c.addr_sel = 1'b1; c.mem_cmd = 2'b01;
        exp_q.push_back(c);
        c = st_only(S_UPD_PC); c.load_pc = 1'b1;
        exp_q.push_back(c);
        exp_q.push_back(st_only(S_DECODE));
    endtask

    task automatic push_mov_imm(input logic [2:0] rn);
        ctl_t c;
        c = st_only(S_MOV_IMM); c.writenum = rn; c.vsel = 2'b10; c.write = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_get_a(input logic [2:0] rn);
        ctl_t c;
        c = st_only(S_GET_A); c.readnum = rn; c.loada = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_get_b(input logic [2:0] rm);
        ctl_t c;
        c = st_only(S_GET_B); c.readnum = rm; c.loadb = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_alu(input logic [1:0] sh, input logic [1:0] aop,
                            input logic a0, input logic is_cmp);
        ctl_t c;
        c = st_only(S_ALU); c.shift = sh; c.alu_op = aop; c.asel = a0;
        if (is_cmp) c.loads = 1'b1; else c.loadc = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_wr_reg(input logic [2:0] rd);
        ctl_t c;
        c = st_only(S_WR_REG); c.writenum = rd; c.write = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_addr_path();
        ctl_t c;
        c = st_only(S_ADDR); c.bsel = 1'b1; c.loadc = 1'b1;
        exp_q.push_back(c);
        c = st_only(S_LD_ADDR); c.load_addr = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_ldr_tail(input logic [2:0] rd);
        ctl_t c;
        c = st_only(S_LDR_RD1); c.mem_cmd = 2'b01;
        exp_q.push_back(c);
        c = st_only(S_LDR_RD2); c.mem_cmd = 2'b01; c.writenum = rd;
        c.vsel = 2'b11; c.write = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_str_getb(input logic [2:0] rd);
        ctl_t c;
        c = st_only(S_STR_GETB); c.readnum = rd; c.loadb = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_str_c();
        ctl_t c;
        c = st_only(S_STR_C); c.asel = 1'b1; c.loadc = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_str_wr();
        ctl_t c;
        c = st_only(S_STR_WR); c.mem_cmd = 2'b10;
        exp_q.push_back(c);
    endtask

    task automatic push_halt();
        ctl_t c;
        c = st_only(S_HALT); c.halted = 1'b1;
        exp_q.push_back(c);
    endtask

    // Scoreboard: pop one expected vector and compare with the current outputs
    task automatic check_now(input string tag);
        ctl_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got %h, expected queue empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: got %h (state %0d) want %h (state %0d)",
                       tag, obs, obs.st, e, e.st);
            end
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            check_now(tag);
            step();
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] got,
                           input logic [15:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    initial begin
        reset = 1'b1;
        mdata = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        push_rst();
        check_now("reset_hold");
        check16("reset_sximm5", sximm5, 16'h0000);
        check16("reset_sximm8", sximm8, 16'h0000);
        reset = 1'b0;
        step();

        // MOV R0,#7 : 5 cycles
        mdata = 16'hD007;
        push_fetch(); push_mov_imm(3'd0);
        drain("mov_imm");
        check16("mov_imm_sximm8", sximm8, 16'h0007);

        // ADD R2,R1,R0,LSL#1 : 8 cycles
        mdata = 16'hA148;
        push_fetch(); push_get_a(3'd1); push_get_b(3'd0);
        push_alu(2'b01, 2'b00, 1'b0, 1'b0); push_wr_reg(3'd2);
        drain("add");

        // CMP R0,R0 : 7 cycles, status only
        mdata = 16'hA800;
        push_fetch(); push_get_a(3'd0); push_get_b(3'd0);
        push_alu(2'b00, 2'b01, 1'b0, 1'b1);
        drain("cmp");

        // MOV R5,R3,LSR : 7 cycles, A forced to zero
        mdata = 16'hC0B3;
        push_fetch(); push_get_b(3'd3);
        push_alu(2'b10, 2'b00, 1'b1, 1'b0); push_wr_reg(3'd5);
        drain("mov_reg");

        // MVN R1,R6,ASR : 7 cycles
        mdata = 16'hB83E;
        push_fetch(); push_get_b(3'd6);
        push_alu(2'b11, 2'b11, 1'b0, 1'b0); push_wr_reg(3'd1);
        drain("mvn");

        // LDR R3,[R0,#2] : 9 cycles
        mdata = 16'h6062;
        push_fetch(); push_get_a(3'd0); push_addr_path(); push_ldr_tail(3'd3);
        drain("ldr");
        check16("ldr_sximm5", sximm5, 16'h0002);

        // STR R3,[R0,#3] : 10 cycles
        mdata = 16'h8063;
        push_fetch(); push_get_a(3'd0); push_addr_path();
        push_str_getb(3'd3); push_str_c(); push_str_wr();
        drain("str");
        check16("str_sximm5", sximm5, 16'h0003);

        // MOV R1,#-3 : negative immediates sign-extend
        mdata = 16'hD1FD;
        push_fetch(); push_mov_imm(3'd1);
        drain("mov_neg");
        check16("neg_sximm8", sximm8, 16'hFFFD);
        check16("neg_sximm5", sximm5, 16'hFFFD);

        // Illegal opcode 001 and illegal MOV op 01 act as NOP
        mdata = 16'h2000;
        push_fetch();
        drain("illegal_opc");
        mdata = 16'hC800;
        push_fetch();
        drain("illegal_mov_op");

        // Reset asserted during STR_C: no store issued
        mdata = 16'h8063;
        push_fetch(); push_get_a(3'd0); push_addr_path(); push_str_getb(3'd3);
        drain("str_pre_reset");
        push_str_c();
        check_now("str_c");
        reset = 1'b1;
        step();
        push_rst();
        check_now("reset_mid_str");
        reset = 1'b0;
        step();

        // HALT: stays halted until reset
        mdata = 16'hE000;
        push_fetch();
        repeat (4) push_halt();
        drain("halt");
        push_halt();
        check_now("halt_hold");
        reset = 1'b1;
        step();
        push_rst();
        check_now("reset_mid_halt");
        reset = 1'b0;
        step();
        push_if1();
        check_now("if1_after_halt");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
